// File: rtl/ecc_bus_arbiter_if.sv
// rtl/ecc_bus_arbiter_if.sv - bus bundle between the ECC arbiter, its requesters and the encoder
//
// Purpose: groups requester handshake, encoder drive/return, tagged output and
// error-counter signals of ecc_bus_arbiter.
// Ports (signals):
//   req_valid/req_data/req_ready : requester words in, one-hot registered grant out
//   enc_valid/enc_data           : drive to encoder valid/data_in
//   enc_code/enc_err             : encoder data_out/ecc_error return
//   out_valid/out_code/out_id/out_err : tagged codeword stream
//   err_clr/err_count            : error counter clear and value
// Modports: master = arbiter side, slave = environment (requesters + encoder + sink).
interface ecc_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int CODE_W  = 39
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      enc_valid;
  logic [DATA_W-1:0]         enc_data;
  logic [CODE_W-1:0]         enc_code;
  logic                      enc_err;
  logic                      out_valid;
  logic [CODE_W-1:0]         out_code;
  logic [ID_W-1:0]           out_id;
  logic                      out_err;
  logic                      err_clr;
  logic [15:0]               err_count;

  modport master (
    input  req_valid, req_data, enc_code, enc_err, err_clr,
    output req_ready, enc_valid, enc_data, out_valid, out_code, out_id, out_err, err_count
  );

  modport slave (
    output req_valid, req_data, enc_code, enc_err, err_clr,
    input  req_ready, enc_valid, enc_data, out_valid, out_code, out_id, out_err, err_count
  );
endinterface

// File: rtl/ecc_bus_arbiter.sv
// rtl/ecc_bus_arbiter.sv - round-robin burst arbiter sharing one ECC encoder
//
// Purpose: grants bursts of up to BURST_MAX words to one requester at a time,
// drives the shared encoder, tags each in-flight word with its source and
// returns tagged codewords; keeps a saturating count of encoder errors.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : ecc_bus_arbiter_if.master (requesters, encoder, tagged output, error counter)
module ecc_bus_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int CODE_W    = 39,
  parameter int ENC_LAT   = 1,
  parameter int BURST_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  ecc_bus_arbiter_if.master    bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_n;
  logic [ID_W-1:0]  owner, owner_n;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_n;

  logic [DATA_W-1:0] words [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  logic              owner_valid;
  logic              beat;
  logic [ID_W-1:0]   next_ptr;
  logic [ID_W-1:0]   scan_ptr;
  logic [NUM_REQ-1:0] scan_mask;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   win;
  logic              win_found;

  assign owner_valid = bus.req_valid[owner];
  assign beat        = (state == BURST) && owner_valid;
  assign next_ptr    = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // Arbitration inputs depend only on registers and req_valid, so the
  // winner can feed the FSM without a combinational loop. In BURST the scan
  // always starts past the owner; an owner that dropped valid is excluded.
  always_comb begin
    scan_ptr  = rr_ptr;
    scan_mask = bus.req_valid;
    if (state == BURST) begin
      scan_ptr = next_ptr;
      if (!owner_valid) begin
        scan_mask = bus.req_valid & ~(NUM_REQ'(1) << owner);
      end
    end
  end

  // Scan downward so the candidate closest to scan_ptr is written last.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(scan_ptr) + k) % NUM_REQ);
      if (scan_mask[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    rr_ptr_n    = rr_ptr;
    burst_cnt_n = burst_cnt;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_n     = BURST;
          owner_n     = win;
          burst_cnt_n = '0;
        end
      end
      BURST: begin
        if (!owner_valid || burst_cnt == CNT_LAST) begin
          rr_ptr_n = next_ptr;
          if (win_found) begin
            owner_n     = win;
            burst_cnt_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          burst_cnt_n = burst_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Grant is a pure function of registered state and owner.
  assign bus.req_ready = (state == BURST) ? (NUM_REQ'(1) << owner) : '0;

  // Encoder drive plus tag pipeline: stage 0 lines up with enc_valid, the
  // tail (stage ENC_LAT) lines up with the encoder's data_out.
  logic              enc_valid_q;
  logic [DATA_W-1:0] enc_data_q;
  logic [ENC_LAT:0]  tag_v;
  logic [ID_W-1:0]   tag_id [ENC_LAT+1];

  always_ff @(posedge clk) begin
    if (reset) begin
      enc_valid_q <= 1'b0;
      enc_data_q  <= '0;
      tag_v       <= '0;
    end else begin
      enc_valid_q <= beat;
      if (beat) begin
        enc_data_q <= words[owner];
      end
      tag_v <= {tag_v[ENC_LAT-1:0], beat};
    end
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= owner;
    for (int i = 1; i <= ENC_LAT; i++) begin
      tag_id[i] <= tag_id[i-1];
    end
  end

  logic out_valid;
  assign out_valid     = tag_v[ENC_LAT];
  assign bus.enc_valid = enc_valid_q;
  assign bus.enc_data  = enc_data_q;
  assign bus.out_valid = out_valid;
  assign bus.out_code  = bus.enc_code;
  assign bus.out_err   = bus.enc_err;
  assign bus.out_id    = out_valid ? tag_id[ENC_LAT] : '0;

  logic [15:0] err_count_q;
  always_ff @(posedge clk) begin
    if (reset || bus.err_clr) begin
      err_count_q <= '0;
    end else if (out_valid && bus.enc_err && err_count_q != 16'hFFFF) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end
  assign bus.err_count = err_count_q;
endmodule
